// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - fetch-side jump, load-use, flush and halt control
// Optional feature macro: PC_BRANCH_CTRL_PERF_EN (adds stall_count / jump_count outputs)
module pc_branch_ctrl #(
  parameter int INS_W        = 20,
  parameter int ADDR_W       = 8,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  input  logic              zero_flag,
  input  logic              carry_flag,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              pc_mux_sel,
  output logic              stall,
  output logic              stall_pm,
  output logic              flush,
`ifdef PC_BRANCH_CTRL_PERF_EN
  output logic [15:0]       stall_count,
  output logic [15:0]       jump_count,
`endif
  output logic              halted
);

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_LD  = 5'b10100;
  localparam logic [4:0] OP_JMP = 5'b11000;
  localparam logic [4:0] OP_JZ  = 5'b11001;
  localparam logic [4:0] OP_JC  = 5'b11010;
  localparam logic [4:0] OP_HLT = 5'b11111;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    LSTALL = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t state, state_next;

  logic              ld_pending;
  logic [2:0]        ld_rd;
  logic [1:0]        flush_cnt, flush_cnt_next;
  logic [ADDR_W-1:0] jmp_reg;
  logic              ld_set;
  logic              jump_take;

  // Instruction fields
  logic [4:0]        opcode;
  logic [2:0]        rd, rs1, rs2;
  logic [ADDR_W-1:0] target;

  assign opcode = ins[19:15];
  assign rd     = ins[14:12];
  assign rs1    = ins[11:9];
  assign rs2    = ins[8:6];
  assign target = ins[ADDR_W-1:0];

  logic is_ld, is_hlt, is_alu, jump_taken, hazard;

  assign is_ld      = (opcode == OP_LD);
  assign is_hlt     = (opcode == OP_HLT);
  // NOP shares the bit4 = 0 space but has no source operands, so it never stalls
  assign is_alu     = !opcode[4] && (opcode != OP_NOP);
  assign jump_taken = (opcode == OP_JMP) ||
                      ((opcode == OP_JZ) && zero_flag) ||
                      ((opcode == OP_JC) && carry_flag);
  assign hazard     = ld_pending && is_alu && ((rs1 == ld_rd) || (rs2 == ld_rd));

  // Moore outputs decoded from state
  assign flush  = (state == FLUSH);
  assign halted = (state == HALT);

  // State register plus load-tracking, flush counter and last jump target
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      ld_pending <= 1'b0;
      ld_rd      <= 3'd0;
      flush_cnt  <= 2'd0;
      jmp_reg    <= '0;
    end else begin
      state      <= state_next;
      flush_cnt  <= flush_cnt_next;
      ld_pending <= ld_set;
      if (ld_set) begin
        ld_rd <= rd;
      end
      if (jump_take) begin
        jmp_reg <= target;
      end
    end
  end

  // Next-state and Mealy outputs; reset forces the fetch controls to idle values
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    pc_mux_sel     = 1'b1;
    jmp_loc        = jmp_reg;
    stall          = 1'b0;
    stall_pm       = 1'b0;
    ld_set         = 1'b0;
    jump_take      = 1'b0;

    case (state)
      RUN, LSTALL: begin
        if (is_hlt) begin
          // Hold the PC on the HLT so nothing behind it is fetched
          stall      = 1'b1;
          stall_pm   = 1'b1;
          state_next = HALT;
        end else if (jump_taken) begin
          pc_mux_sel     = 1'b0;
          jmp_loc        = target;
          jump_take      = 1'b1;
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end else if ((state == RUN) && hazard) begin
          // Replay the consumer once so the load result is available
          stall      = 1'b1;
          stall_pm   = 1'b1;
          state_next = LSTALL;
        end else begin
          ld_set     = is_ld;
          state_next = RUN;
        end
      end
      FLUSH: begin
        if (flush_cnt <= 2'd1) begin
          state_next = RUN;
        end else begin
          flush_cnt_next = flush_cnt - 2'd1;
        end
      end
      HALT: begin
        stall    = 1'b1;
        stall_pm = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase

    if (!reset) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = '0;
      stall      = 1'b0;
      stall_pm   = 1'b0;
      jump_take  = 1'b0;
      ld_set     = 1'b0;
    end
  end

`ifdef PC_BRANCH_CTRL_PERF_EN
  // Saturating event counters for stalled and redirected fetch cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= 16'd0;
      jump_count  <= 16'd0;
    end else begin
      if (stall && (state != HALT) && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (jump_take && (jump_count != 16'hFFFF)) begin
        jump_count <= jump_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
Fetch-side control unit that consumes the instruction stream from the program counter / program memory block and drives that block's control inputs: jmp_loc, pc_mux_sel, stall and stall_pm. It decodes jumps (unconditional and flag-conditional), load-use hazards and halt. From these it produces redirect, freeze and flush controls. It sits between the program counter and the decode/execute stages of the pipelined processor and closes the fetch control loop.

Parameters:
INS_W, 20, instruction width; field map below assumes 20.
ADDR_W, 8, program address width; jump target width.
FLUSH_CYCLES, 1, number of cycles flush is held after a taken jump; legal range 1..3.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset: sampled on rising edge of clk, 0 = reset.
ins  input  INS_W  current fetched instruction from program counter block.
zero_flag  input  1  ALU zero flag, valid in the same cycle as ins.
carry_flag  input  1  ALU carry flag, valid in the same cycle as ins.
jmp_loc  output  ADDR_W  jump target to program counter.
pc_mux_sel  output  1  1 = PC+1 (sequential), 0 = load jmp_loc.
stall  output  1  1 = hold PC.
stall_pm  output  1  1 = hold program-memory output register (replay ins).
flush  output  1  1 = downstream stage must treat its instruction as NOP.
halted  output  1  1 = HLT executed; core frozen until reset.

Behaviour:
- Field map: opcode = ins[19:15], rd = ins[14:12], rs1 = ins[11:9], rs2 = ins[8:6], target/addr = ins[7:0].
- Opcodes: NOP 00000; ALU class = any opcode with bit4 = 0; LD 10100; JMP 11000; JZ 11001; JC 11010; HLT 11111. Any other bit4 = 1 opcode is treated as NOP.
- Reset (reset = 0 at an edge): state = RUN, ld_pending = 0, ld_rd = 0, flush counter = 0. Outputs: pc_mux_sel = 1, jmp_loc = 0, stall = 0, stall_pm = 0, flush = 0, halted = 0. Reset overrides every state, including mid-FLUSH and HALT.
- FSM states: RUN, FLUSH, LSTALL, HALT.
- Output timing: jmp_loc, pc_mux_sel, stall and stall_pm are Mealy outputs (combinational from state + ins + flags). flush and halted are Moore outputs (decoded from state).
- RUN, taken jump (JMP; JZ with zero_flag = 1; JC with carry_flag = 1):
  - Same cycle: pc_mux_sel = 0, jmp_loc = ins[7:0].
  - Next edge: go to FLUSH and load the counter with FLUSH_CYCLES.
  - Not-taken conditional: pc_mux_sel = 1, remain in RUN, jmp_loc holds its last value.
- RUN, LD: set ld_pending = 1 and ld_rd = rd at the edge. ld_pending clears at the following edge regardless of the next instruction.
- RUN, ALU-class instruction while ld_pending = 1 and (rs1 == ld_rd or rs2 == ld_rd):
  - Same cycle: stall = 1, stall_pm = 1.
  - Next edge: go to LSTALL.
  - Non-matching or non-ALU instructions do not stall.
- LSTALL: stall = 0, stall_pm = 0, flush = 0; the replayed ins is decoded normally. Hazard check is suppressed this cycle (ld_pending already 0). Next edge: back to RUN, or to FLUSH/HALT if the replayed ins is a taken jump or HLT.
- FLUSH: flush = 1, pc_mux_sel = 1, stall = 0. Instructions seen here are ignored (no jump, LD or HLT decode). The counter decrements each cycle; when it reaches 1, the next edge returns to RUN. Exactly FLUSH_CYCLES flush cycles follow a taken jump.
- RUN, HLT: stall = 1, stall_pm = 1 the same cycle. Next edge: go to HALT.
- HALT: stall = 1, stall_pm = 1, halted = 1, pc_mux_sel = 1. Exits only via reset.
- Priority within RUN: HLT > taken jump > load-use stall > sequential.

Optional Feature:
PC_BRANCH_CTRL_PERF_EN:
- Defined: adds output ports stall_count[15:0] and jump_count[15:0], both reset to 0.
  - stall_count increments on every edge where stall = 1 and state != HALT.
  - jump_count increments on every taken jump.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset = 0 for 2 edges with ins = JMP 0x08 -> pc_mux_sel = 1, jmp_loc = 0, stall = 0, flush = 0, halted = 0. Release reset -> next cycle pc_mux_sel = 0, jmp_loc = 0x08, then exactly FLUSH_CYCLES cycles of flush = 1.
- Conditional jumps: JZ 0x20 with zero_flag = 0 -> pc_mux_sel = 1, no flush. JZ 0x20 with zero_flag = 1 -> pc_mux_sel = 0, jmp_loc = 0x20, flush next cycle. Repeat the pair for JC with carry_flag.
- Load-use: LD rd = 3, then ALU rs1 = 3 -> stall = stall_pm = 1 for exactly 1 cycle, then normal. LD rd = 3, then ALU rs1 = 2, rs2 = 5 -> no stall.
- Jump during FLUSH: FLUSH_CYCLES = 2, JMP 0x10 followed by JMP 0x40 and HLT in the flush window -> both ignored, pc_mux_sel = 1, halted = 0, RUN resumes after 2 flush cycles.
- Halt: HLT -> stall = stall_pm = 1 the same cycle, halted = 1 next cycle and held for 10+ cycles regardless of ins. Pulse reset = 0 -> all outputs return to reset values.
- Reset mid-LSTALL/FLUSH: assert reset = 0 during LSTALL and again during FLUSH -> next cycle state RUN, flush = 0, stall = 0. With PC_BRANCH_CTRL_PERF_EN defined: counters return to 0, and 3 taken jumps give jump_count = 3.
